ladybird_mem_arbiter: RTL and testbench
=======================================

# ladybird_mem_arbiter

Arbiter and sequencer that shares the single memory request channel between the core's instruction-fetch requester and its load/store requester. Sits between the fetch/memory pipeline stages and the memory/AXI front end. Keeps at most one transaction outstanding and routes each response back to the requester that issued it. Gives data accesses priority, with a starvation limit that guarantees fetch progress.

## Interface
- XLEN, 32, address/data width
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending; range 1..15
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted
- i_req_addr  in  XLEN  fetch address (pc)
- i_rsp_valid  out  1  fetch response valid
- i_rsp_data  out  XLEN  fetched instruction
- d_req_valid  in  1  load/store request valid
- d_req_ready  out  1  load/store request accepted
- d_req_addr  in  XLEN  data address
- d_req_data  in  XLEN  store data
- d_req_we  in  1  1 = store
- d_req_funct  in  3  funct3 (size/sign)
- d_rsp_valid  out  1  load data / store ack valid
- d_rsp_data  out  XLEN  load data (don't-care for stores)
- m_req_valid  out  1  request to memory
- m_req_ready  in  1  memory accepts request
- m_req_addr  out  XLEN  muxed address
- m_req_data  out  XLEN  muxed store data (0 for fetch)
- m_req_we  out  1  muxed write enable (0 for fetch)
- m_req_funct  out  3  muxed funct3 (3'b010 for fetch)
- m_rsp_valid  in  1  memory response (also returned for stores)
- m_rsp_data  in  XLEN  response data
- busy  out  1  transaction outstanding (state != IDLE)
- err_stray  out  1  sticky: m_rsp_valid seen with nothing outstanding

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D.
- IDLE: winner is chosen combinationally from the current valids. m_req_* is driven from the winner. m_req_valid equals the winner's valid. The winner's ready equals m_req_ready; the loser's ready is 0.
- Arbitration rules:
  - Only one valid: that requester wins.
  - Both valid: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Lock: if m_req_valid=1 and m_req_ready=0, the winner is registered in a lock register. The same requester stays granted until the handshake completes, even if the other requester raises valid or starve_cnt changes. Requesters hold valid and payload stable until ready. The lock clears on handshake.
- Transitions:
  - Handshake with fetch winner: IDLE -> WAIT_I.
  - Handshake with data winner: IDLE -> WAIT_D.
- WAIT_I / WAIT_D: m_req_valid=0 and both readies are 0.
  - On m_rsp_valid, m_rsp_data is forwarded combinationally to the owner (i_rsp_* or d_rsp_*) in the same cycle, and the FSM returns to IDLE.
  - The non-owner rsp_valid is always 0.
- starve_cnt (4 bits) updates on each handshake only:
  - Data grant with i_req_valid=1: increment, saturating at STARVE_LIMIT.
  - Data grant with i_req_valid=0: clear.
  - Fetch grant: clear.
- m_rsp_valid in IDLE: ignored (no rsp_valid output) and err_stray is set.
- Response data is never modified; XLEN-bit pass-through.

## Timing
- Reset values (nrst=0 at clk edge):
  - state IDLE, starve_cnt 0, lock clear, err_stray 0, busy 0.
  - All ready/valid outputs 0 unless combinationally driven by IDLE arbitration, so m_req_valid may be 1 in the first post-reset cycle if inputs are valid.
- Reset mid-transaction: returns to IDLE and drops ownership. A later response for the dropped transaction is handled as stray (err_stray=1).
- Request latency: 0 cycles arbiter-to-memory (combinational in IDLE).
- Minimum spacing between handshakes: 2 cycles (handshake, then response earliest next cycle, then IDLE).
- Response latency: 0 cycles, m_rsp_valid -> i/d_rsp_valid.
- m_rsp_valid in the same cycle as the request handshake is illegal; the memory responds at least 1 cycle after accept.
- A new arbitration takes place in the cycle after the response. It uses the starve_cnt updated at the previous handshake.

## Test plan
- Fetch only, i_req_addr=0x0000_1000, m_req_ready=1, response 0x0000_0013 one cycle later:
  - Required: m_req_addr=0x1000, m_req_we=0, m_req_funct=3'b010.
  - Required: i_rsp_valid=1 with data 0x13; d_rsp_valid never 1.
- Simultaneous fetch 0x100 and store 0x2000/data 0xDEADBEEF:
  - Required: data granted first (m_req_we=1, m_req_data=0xDEADBEEF), then d_rsp_valid ack.
  - Required: fetch granted next.
- Starvation, STARVE_LIMIT=4, fetch continuously valid, data valid every cycle: exactly 4 data grants, then 1 fetch grant, then starve_cnt=0 and the pattern repeats.
- Lock: data valid while m_req_ready=0 for 3 cycles, and fetch raises valid in cycle 2 with starve_cnt=STARVE_LIMIT:
  - Required: m_req_addr stays the data address until accept.
  - Required: i_req_ready=0 throughout.
- Reset mid-transaction:
  - Stimulus: nrst low for 1 cycle in WAIT_D.
  - Required: busy=0 next cycle.
  - Required: the late m_rsp_valid produces no d_rsp_valid and sets err_stray=1, which stays set until the next reset.

Source files
------------

// File: rtl/ladybird_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_mem_arbiter
// Brief    : Shares one memory request channel between instruction fetch and
//            load/store, one transaction outstanding, data-first with a
//            starvation limit that guarantees fetch progress.
// Revision : 1.0 - initial release
// ============================================================================
module ladybird_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            nrst,
    // instruction fetch requester
    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    output logic            i_rsp_valid,
    output logic [XLEN-1:0] i_rsp_data,
    // load/store requester
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic [XLEN-1:0] d_req_data,
    input  logic            d_req_we,
    input  logic [2:0]      d_req_funct,
    output logic            d_rsp_valid,
    output logic [XLEN-1:0] d_rsp_data,
    // memory channel
    output logic            m_req_valid,
    input  logic            m_req_ready,
    output logic [XLEN-1:0] m_req_addr,
    output logic [XLEN-1:0] m_req_data,
    output logic            m_req_we,
    output logic [2:0]      m_req_funct,
    input  logic            m_rsp_valid,
    input  logic [XLEN-1:0] m_rsp_data,
    // status
    output logic            busy,
    output logic            err_stray
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
    localparam logic [2:0] c_funct_word   = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    logic       r_lock_valid;
    logic       r_lock_d;
    logic       r_err_stray;

    logic       w_idle;
    logic       w_sel_d;
    logic       w_win_valid;
    logic       w_hs;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
            r_lock_valid <= 1'b0;
            r_lock_d     <= 1'b0;
            r_err_stray  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            // A stalled offer is pinned to its requester until it is accepted
            if (w_hs) begin
                r_lock_valid <= 1'b0;
            end else if (m_req_valid) begin
                r_lock_valid <= 1'b1;
                r_lock_d     <= w_sel_d;
            end
            if (w_idle && m_rsp_valid) begin
                r_err_stray <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_idle       = (r_state == ST_IDLE);

        if (r_lock_valid) begin
            w_sel_d = r_lock_d;
        end else if (d_req_valid && i_req_valid) begin
            w_sel_d = (r_starve_cnt != c_starve_limit);
        end else begin
            w_sel_d = d_req_valid;
        end

        w_win_valid = w_sel_d ? d_req_valid : i_req_valid;
        m_req_valid = w_idle && w_win_valid;
        w_hs        = m_req_valid && m_req_ready;
        i_req_ready = w_idle && !w_sel_d && m_req_ready;
        d_req_ready = w_idle && w_sel_d && m_req_ready;

        m_req_addr  = w_sel_d ? d_req_addr  : i_req_addr;
        m_req_data  = w_sel_d ? d_req_data  : '0;
        m_req_we    = w_sel_d ? d_req_we    : 1'b0;
        m_req_funct = w_sel_d ? d_req_funct : c_funct_word;

        i_rsp_valid = (r_state == ST_WAIT_I) && m_rsp_valid;
        d_rsp_valid = (r_state == ST_WAIT_D) && m_rsp_valid;
        i_rsp_data  = m_rsp_data;
        d_rsp_data  = m_rsp_data;

        busy        = !w_idle;
        err_stray   = r_err_stray;

        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = w_sel_d ? ST_WAIT_D : ST_WAIT_I;
                end
            end
            ST_WAIT_I, ST_WAIT_D: begin
                if (m_rsp_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Count data grants that bypassed a waiting fetch
        if (w_hs) begin
            if (w_sel_d && i_req_valid) begin
                w_starve_nxt = (r_starve_cnt >= c_starve_limit) ? c_starve_limit
                                                                : r_starve_cnt + 4'd1;
            end else begin
                w_starve_nxt = 4'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ladybird_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ladybird_mem_arbiter
// Brief    : Scoreboard bench for ladybird_mem_arbiter with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ladybird_mem_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            i_req_valid = 1'b0;
    logic            i_req_ready;
    logic [XLEN-1:0] i_req_addr = '0;
    logic            i_rsp_valid;
    logic [XLEN-1:0] i_rsp_data;
    logic            d_req_valid = 1'b0;
    logic            d_req_ready;
    logic [XLEN-1:0] d_req_addr = '0;
    logic [XLEN-1:0] d_req_data = '0;
    logic            d_req_we = 1'b0;
    logic [2:0]      d_req_funct = 3'b000;
    logic            d_rsp_valid;
    logic [XLEN-1:0] d_rsp_data;
    logic            m_req_valid;
    logic            m_req_ready = 1'b0;
    logic [XLEN-1:0] m_req_addr;
    logic [XLEN-1:0] m_req_data;
    logic            m_req_we;
    logic [2:0]      m_req_funct;
    logic            m_rsp_valid = 1'b0;
    logic [XLEN-1:0] m_rsp_data = '0;
    logic            busy;
    logic            err_stray;

    always #5 clk = ~clk;

    ladybird_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .nrst(nrst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_data(d_req_data), .d_req_we(d_req_we), .d_req_funct(d_req_funct),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_data(m_req_data), .m_req_we(m_req_we), .m_req_funct(m_req_funct),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
        .busy(busy), .err_stray(err_stray)
    );

    // who: 1 = fetch, 2 = data
    typedef struct {
        int          who;
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [2:0]  funct;
        logic        rdy;
    } req_t;
    typedef struct {
        int          who;
        logic [31:0] data;
    } rsp_t;
    typedef struct {
        logic busy;
        logic err;
    } st_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    st_t  st_q[$];
    bit   grant_log[$];

    int          mo_owner = 0;
    int          mo_lock = 0;
    int          mo_starve = 0;
    bit          mo_err = 1'b0;
    bit          hs_i = 1'b0;
    bit          hs_d = 1'b0;
    int          rsp_cnt = 0;
    int          lat_fix = 0;
    bit          rsp_fix_en = 1'b0;
    logic [31:0] rsp_fix_val = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got event/no-event contrary to expected", name);
    endtask

    // One cycle: memory side, reference-model expectations, then advance.
    task automatic step();
        req_t r;
        rsp_t p;
        st_t  s;
        int   win;
        m_rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                m_rsp_valid = 1'b1;
                m_rsp_data  = rsp_fix_en ? rsp_fix_val : $urandom;
            end
        end
        hs_i = 1'b0;
        hs_d = 1'b0;
        s.busy = (mo_owner != 0);
        s.err  = mo_err;
        st_q.push_back(s);
        if (!nrst) begin
            mo_owner = 0; mo_lock = 0; mo_starve = 0; mo_err = 1'b0;
        end else if (mo_owner == 0) begin
            if (m_rsp_valid) mo_err = 1'b1;
            win = 0;
            if (mo_lock != 0) win = mo_lock;
            else if (i_req_valid && d_req_valid) win = (mo_starve == LIMIT) ? 1 : 2;
            else if (d_req_valid) win = 2;
            else if (i_req_valid) win = 1;
            if (win != 0) begin
                r.who = win;
                r.rdy = m_req_ready;
                if (win == 2) begin
                    r.addr = d_req_addr; r.data = d_req_data; r.we = d_req_we; r.funct = d_req_funct;
                end else begin
                    r.addr = i_req_addr; r.data = '0; r.we = 1'b0; r.funct = 3'b010;
                end
                req_q.push_back(r);
                if (m_req_ready) begin
                    if (win == 2) begin
                        mo_starve = i_req_valid ? ((mo_starve < LIMIT) ? mo_starve + 1 : LIMIT) : 0;
                        hs_d = 1'b1;
                    end else begin
                        mo_starve = 0;
                        hs_i = 1'b1;
                    end
                    mo_owner = win;
                    mo_lock  = 0;
                    rsp_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
                end else begin
                    mo_lock = win;
                end
            end
        end else if (m_rsp_valid) begin
            p.who  = mo_owner;
            p.data = m_rsp_data;
            rsp_q.push_back(p);
            mo_owner = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        m_req_ready = 1'b0;
        rsp_cnt     = 0;
        nrst        = 1'b0;
        step();
        step();
        nrst = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    initial begin
        st_t  s;
        req_t e;
        rsp_t p;
        forever begin
            @(negedge clk);
            #4;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("busy", 32'(busy), 32'(s.busy));
                chk("err_stray", 32'(err_stray), 32'(s.err));
            end
            if (m_req_valid === 1'b1) begin
                if (req_q.size() == 0) fail_now("unexpected_m_req_valid");
                else begin
                    e = req_q.pop_front();
                    chk("m_req_addr", m_req_addr, e.addr);
                    chk("m_req_data", m_req_data, e.data);
                    chk("m_req_we", 32'(m_req_we), 32'(e.we));
                    chk("m_req_funct", 32'(m_req_funct), 32'(e.funct));
                    chk("i_req_ready", 32'(i_req_ready), 32'((e.who == 1) && e.rdy));
                    chk("d_req_ready", 32'(d_req_ready), 32'((e.who == 2) && e.rdy));
                end
                if (m_req_ready === 1'b1) grant_log.push_back(d_req_ready === 1'b1);
            end
            if (i_rsp_valid === 1'b1) begin
                if (rsp_q.size() == 0) fail_now("unexpected_i_rsp_valid");
                else begin
                    p = rsp_q.pop_front();
                    chk("i_rsp_owner", 32'(p.who), 32'd1);
                    chk("i_rsp_data", i_rsp_data, p.data);
                end
            end
            if (d_rsp_valid === 1'b1) begin
                if (rsp_q.size() == 0) fail_now("unexpected_d_rsp_valid");
                else begin
                    p = rsp_q.pop_front();
                    chk("d_rsp_owner", 32'(p.who), 32'd2);
                    chk("d_rsp_data", d_rsp_data, p.data);
                end
            end
            if (req_q.size() > 0) begin
                fail_now("missing_m_req_valid");
                req_q.delete();
            end
            if (rsp_q.size() > 0) begin
                fail_now("missing_rsp_valid");
                rsp_q.delete();
            end
        end
    end

    task automatic check_log(input string name, input int idx, input bit exp_d);
        if (idx >= grant_log.size()) fail_now(name);
        else chk(name, 32'(grant_log[idx]), 32'(exp_d));
    endtask

    initial begin
        int dg;
        @(negedge clk);

        // Fetch only, fixed response 0x13
        do_reset();
        lat_fix = 1; rsp_fix_en = 1'b1; rsp_fix_val = 32'h0000_0013;
        grant_log.delete();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_1000; m_req_ready = 1'b1;
        step();
        i_req_valid = 1'b0;
        step(); step(); step();
        check_log("fetch_only_grant", 0, 1'b0);
        rsp_fix_en = 1'b0;

        // Simultaneous fetch and store: store first, then fetch
        do_reset();
        grant_log.delete();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_0100;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_2000; d_req_data = 32'hDEAD_BEEF;
        d_req_we = 1'b1; d_req_funct = 3'b010; m_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (hs_d) d_req_valid = 1'b0;
            if (hs_i) i_req_valid = 1'b0;
        end
        check_log("simul_first_data", 0, 1'b1);
        check_log("simul_then_fetch", 1, 1'b0);

        // Starvation: both requesters always valid
        do_reset();
        grant_log.delete();
        i_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b0; m_req_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (hs_i) i_req_addr = i_req_addr + 32'd4;
            if (hs_d) d_req_addr = $urandom;
        end
        for (int k = 0; k < 2 * (LIMIT + 1); k++)
            check_log("starve_pattern", k, (k % (LIMIT + 1)) != LIMIT);

        // Lock: bring starve count to the limit, then stall a data offer
        do_reset();
        i_req_valid = 1'b1; i_req_addr = 32'h0000_0200;
        d_req_valid = 1'b1; m_req_ready = 1'b1;
        dg = 0;
        for (int k = 0; k < 40 && dg < LIMIT; k++) begin
            step();
            if (hs_d) begin dg++; d_req_addr = $urandom; end
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        step();
        grant_log.delete();
        d_req_valid = 1'b1; d_req_addr = 32'h0000_3000; d_req_data = 32'hCAFE_F00D;
        d_req_we = 1'b1; m_req_ready = 1'b0;
        step();
        i_req_valid = 1'b1;
        step(); step();
        m_req_ready = 1'b1;
        step();
        d_req_valid = 1'b0;
        step(); step();
        i_req_valid = 1'b0;
        step(); step();
        check_log("lock_data_kept", 0, 1'b1);
        check_log("lock_then_fetch", 1, 1'b0);

        // Randomised traffic
        lat_fix = 0;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (hs_i) i_req_valid = 1'b0;
            if (hs_d) d_req_valid = 1'b0;
            if (!i_req_valid && $urandom_range(0, 2) == 0) begin
                i_req_valid = 1'b1; i_req_addr = $urandom & ~32'h3;
            end
            if (!d_req_valid && $urandom_range(0, 2) == 0) begin
                d_req_valid = 1'b1; d_req_addr = $urandom; d_req_data = $urandom;
                d_req_we = 1'($urandom_range(0, 1)); d_req_funct = 3'($urandom_range(0, 7));
            end
            m_req_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset while a load is outstanding; late response becomes stray
        do_reset();
        lat_fix = 3;
        d_req_valid = 1'b1; d_req_addr = 32'h0000_4000; d_req_we = 1'b0; m_req_ready = 1'b1;
        step();
        d_req_valid = 1'b0;
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        for (int k = 0; k < 6; k++) step();
        lat_fix = 0;

        #6;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
